// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: request/ALU/response bundle between requesters, arbiter and the shared ALU, plus ALU op codes.
`ifndef ALU_OP_ADD
`define ALU_OP_ADD 3'd0
`define ALU_OP_SUB 3'd1
`define ALU_OP_AND 3'd2
`define ALU_OP_OR  3'd3
`define ALU_OP_XOR 3'd4
`define ALU_OP_SLT 3'd5
`define ALU_OP_SLL 3'd6
`define ALU_OP_SRL 3'd7
`endif

interface alu_arbiter_if #(parameter int XLEN = 32);
    logic [1:0]      req_valid_i;
    logic [1:0]      req_ready_o;
    logic [XLEN-1:0] req0_a_i;
    logic [XLEN-1:0] req0_b_i;
    logic [2:0]      req0_ctrl_i;
    logic            req0_mod_i;
    logic [XLEN-1:0] req1_a_i;
    logic [XLEN-1:0] req1_b_i;
    logic [2:0]      req1_ctrl_i;
    logic            req1_mod_i;
    logic [XLEN-1:0] alu_a_o;
    logic [XLEN-1:0] alu_b_o;
    logic [2:0]      alu_ctrl_o;
    logic            alu_mod_o;
    logic [XLEN-1:0] alu_result_i;
    logic            alu_zero_i;
    logic            resp_valid_o;
    logic            resp_ready_i;
    logic            resp_id_o;
    logic [XLEN-1:0] resp_result_o;
    logic            resp_zero_o;

    modport slave (
        input  req_valid_i, req0_a_i, req0_b_i, req0_ctrl_i, req0_mod_i,
        input  req1_a_i, req1_b_i, req1_ctrl_i, req1_mod_i,
        input  alu_result_i, alu_zero_i, resp_ready_i,
        output req_ready_o, alu_a_o, alu_b_o, alu_ctrl_o, alu_mod_o,
        output resp_valid_o, resp_id_o, resp_result_o, resp_zero_o
    );

    modport master (
        output req_valid_i, req0_a_i, req0_b_i, req0_ctrl_i, req0_mod_i,
        output req1_a_i, req1_b_i, req1_ctrl_i, req1_mod_i,
        output alu_result_i, alu_zero_i, resp_ready_i,
        input  req_ready_o, alu_a_o, alu_b_o, alu_ctrl_o, alu_mod_o,
        input  resp_valid_o, resp_id_o, resp_result_o, resp_zero_o
    );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between execute (port 0) and branch/address unit (port 1); ALU_ARB_PERF_CNT_EN adds grant/stall counters.
module alu_arbiter #(
    parameter int XLEN       = 32,
    parameter int PRIO_FIXED = 0
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        flush_i,
    alu_arbiter_if.slave bus
`ifdef ALU_ARB_PERF_CNT_EN
    ,
    output logic [31:0] grant_cnt0_o,
    output logic [31:0] grant_cnt1_o,
    output logic [31:0] stall_cnt_o
`endif
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t          state;
    logic            last_grant;
    logic            op_id;
    logic            op_mod;
    logic [2:0]      op_ctrl;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            resp_valid;
    logic            resp_id;
    logic            resp_zero;
    logic [XLEN-1:0] resp_result;
    logic            accept_en;
    logic            winner;
    logic            handshake;
    logic [1:0]      ready;

    // Pick a winner among valid ports and grant it only when a new op can be taken this cycle
    always_comb begin
        accept_en = (state == IDLE) || (state == RESP && bus.resp_ready_i);
        winner    = &bus.req_valid_i ? ((PRIO_FIXED != 0) ? 1'b0 : ~last_grant) : bus.req_valid_i[1];
        ready     = (rst_ni && !flush_i && accept_en && |bus.req_valid_i) ? (winner ? 2'b10 : 2'b01) : 2'b00;
        handshake = |ready;
    end

    // Operation FSM: latch the winning op, run the ALU for one cycle, hold the response until taken
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= IDLE;
            last_grant  <= 1'b1;
            op_id       <= 1'b0;
            op_a        <= '0;
            op_b        <= '0;
            op_ctrl     <= `ALU_OP_ADD;
            op_mod      <= 1'b0;
            resp_valid  <= 1'b0;
            resp_id     <= 1'b0;
            resp_result <= '0;
            resp_zero   <= 1'b0;
        end else if (flush_i) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
        end else begin
            if (handshake) begin
                op_id      <= winner;
                op_a       <= winner ? bus.req1_a_i : bus.req0_a_i;
                op_b       <= winner ? bus.req1_b_i : bus.req0_b_i;
                op_ctrl    <= winner ? bus.req1_ctrl_i : bus.req0_ctrl_i;
                op_mod     <= winner ? bus.req1_mod_i : bus.req0_mod_i;
                last_grant <= winner;
            end
            if (state == EXEC) begin
                resp_valid  <= 1'b1;
                resp_id     <= op_id;
                resp_result <= bus.alu_result_i;
                resp_zero   <= bus.alu_zero_i;
            end else if (state == RESP && bus.resp_ready_i) begin
                resp_valid <= 1'b0;
            end
            state <= handshake ? EXEC :
                     (state == EXEC || (state == RESP && !bus.resp_ready_i)) ? RESP : IDLE;
        end
    end

`ifdef ALU_ARB_PERF_CNT_EN
    // Per-port accepted handshakes and cycles where someone waited without being accepted
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            grant_cnt0_o <= '0;
            grant_cnt1_o <= '0;
            stall_cnt_o  <= '0;
        end else begin
            grant_cnt0_o <= grant_cnt0_o + {31'b0, ready[0]};
            grant_cnt1_o <= grant_cnt1_o + {31'b0, ready[1]};
            stall_cnt_o  <= stall_cnt_o + {31'b0, |bus.req_valid_i & ~handshake};
        end
    end
`endif

    assign bus.req_ready_o   = ready;
    assign bus.alu_a_o       = (state == EXEC) ? op_a : '0;
    assign bus.alu_b_o       = (state == EXEC) ? op_b : '0;
    assign bus.alu_ctrl_o    = (state == EXEC) ? op_ctrl : `ALU_OP_ADD;
    assign bus.alu_mod_o     = (state == EXEC) && op_mod;
    assign bus.resp_valid_o  = resp_valid;
    assign bus.resp_id_o     = resp_id;
    assign bus.resp_result_o = resp_result;
    assign bus.resp_zero_o   = resp_zero;
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: round-robin (g[0]) and fixed-priority (g[1]) arbiters checked against a transaction-level model.
`ifndef ALU_OP_ADD
`define ALU_OP_ADD 3'd0
`define ALU_OP_SUB 3'd1
`endif

module tb_alu_arbiter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fl = 1'b0;
    logic        rr = 1'b0;
    logic [1:0]  v[2];
    logic [31:0] ra[2][2];
    logic [31:0] rb[2][2];
    logic [2:0]  rc[2][2];
    logic        rm[2][2];
    logic [1:0]  rdy[2];
    logic        rv[2];
    logic        rid[2];
    logic        rz[2];
    logic [31:0] rres[2];
    logic [31:0] aa[2];
    logic [2:0]  ac[2];
    logic [1:0]  prer[2];
    logic [31:0] held[2];
    int          total = 0;
    int          bad = 0;
    int          prob = 0;
    int          ogr[2][2];
    bit          inflight[2];
    int          age[2];
    logic        lg[2];
    logic        hs[2];
    logic        w[2];
    logic        mid[2];
    logic        mz[2];
    logic [31:0] mres[2];
    logic [31:0] ma[2];
    logic [2:0]  mctrl[2];

    always #5 clk = ~clk;

    function automatic logic [31:0] alu_fn(logic [31:0] a, logic [31:0] b, logic [2:0] c, logic m);
        case (c)
            3'd0: alu_fn = m ? a - b : a + b;
            3'd1: alu_fn = a - b;
            3'd2: alu_fn = a & b;
            3'd3: alu_fn = a | b;
            3'd4: alu_fn = a ^ b;
            3'd5: alu_fn = {31'b0, $signed(a) < $signed(b)};
            3'd6: alu_fn = a << b[4:0];
            default: alu_fn = m ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
        endcase
    endfunction

    for (genvar d = 0; d < 2; d++) begin : g
        alu_arbiter_if #(.XLEN(32)) bus ();
`ifdef ALU_ARB_PERF_CNT_EN
        logic [31:0] gc0, gc1, sc;
`endif
        alu_arbiter #(.XLEN(32), .PRIO_FIXED(d)) dut (
            .clk_i   (clk),
            .rst_ni  (rst_n),
            .flush_i (fl),
            .bus     (bus)
`ifdef ALU_ARB_PERF_CNT_EN
            ,
            .grant_cnt0_o (gc0),
            .grant_cnt1_o (gc1),
            .stall_cnt_o  (sc)
`endif
        );
        assign bus.req_valid_i  = v[d];
        assign bus.req0_a_i     = ra[d][0];
        assign bus.req0_b_i     = rb[d][0];
        assign bus.req0_ctrl_i  = rc[d][0];
        assign bus.req0_mod_i   = rm[d][0];
        assign bus.req1_a_i     = ra[d][1];
        assign bus.req1_b_i     = rb[d][1];
        assign bus.req1_ctrl_i  = rc[d][1];
        assign bus.req1_mod_i   = rm[d][1];
        assign bus.resp_ready_i = rr;
        assign bus.alu_result_i = alu_fn(bus.alu_a_o, bus.alu_b_o, bus.alu_ctrl_o, bus.alu_mod_o);
        assign bus.alu_zero_i   = bus.alu_result_i == 32'd0;
        assign rdy[d]  = bus.req_ready_o;
        assign rv[d]   = bus.resp_valid_o;
        assign rid[d]  = bus.resp_id_o;
        assign rres[d] = bus.resp_result_o;
        assign rz[d]   = bus.resp_zero_o;
        assign aa[d]   = bus.alu_a_o;
        assign ac[d]   = bus.alu_ctrl_o;
    end

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic refill();
        for (int d = 0; d < 2; d++)
            for (int p = 0; p < 2; p++)
                if (!v[d][p] && int'($urandom_range(99)) < prob) begin
                    ra[d][p] = $urandom;
                    rb[d][p] = ($urandom_range(3) == 0) ? ra[d][p] : $urandom;
                    rc[d][p] = 3'($urandom_range(7));
                    rm[d][p] = 1'($urandom_range(1));
                    v[d][p]  = 1'b1;
                end
    endtask

    task automatic req(int p, logic [31:0] a, logic [31:0] b, logic [2:0] c);
        for (int d = 0; d < 2; d++) begin
            ra[d][p] = a;
            rb[d][p] = b;
            rc[d][p] = c;
            rm[d][p] = 1'b0;
            v[d][p]  = 1'b1;
        end
    endtask

    // One clock: check grant before the edge, advance the model, check registered outputs after it
    task automatic cycle();
        logic [1:0] er;
        logic       can;
        #1;
        for (int d = 0; d < 2; d++) begin
            can   = rst_n && !fl && (!inflight[d] || (age[d] >= 2 && rr));
            w[d]  = (v[d] == 2'b11) ? ((d == 1) ? 1'b0 : ~lg[d]) : v[d][1];
            hs[d] = can && (v[d] != 2'b00);
            er    = hs[d] ? (w[d] ? 2'b10 : 2'b01) : 2'b00;
            prer[d] = rdy[d];
            chk($sformatf("ready[%0d]", d), {30'b0, rdy[d]}, {30'b0, er});
            for (int p = 0; p < 2; p++)
                if (rdy[d][p] && v[d][p]) ogr[d][p]++;
        end
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                inflight[d] = 0;
                lg[d] = 1'b1;
            end else if (fl) begin
                inflight[d] = 0;
            end else begin
                if (inflight[d] && age[d] >= 2 && rr) inflight[d] = 0;
                else if (inflight[d]) age[d]++;
                if (hs[d]) begin
                    inflight[d] = 1;
                    age[d]   = 1;
                    mid[d]   = w[d];
                    ma[d]    = ra[d][w[d]];
                    mctrl[d] = rc[d][w[d]];
                    mres[d]  = alu_fn(ra[d][w[d]], rb[d][w[d]], rc[d][w[d]], rm[d][w[d]]);
                    mz[d]    = mres[d] == 32'd0;
                    lg[d]    = w[d];
                    v[d][w[d]] = 1'b0;
                end
            end
            chk($sformatf("resp_valid[%0d]", d), {31'b0, rv[d]}, {31'b0, inflight[d] && age[d] >= 2});
            if (inflight[d] && age[d] >= 2) begin
                chk($sformatf("resp_id[%0d]", d), {31'b0, rid[d]}, {31'b0, mid[d]});
                chk($sformatf("resp_result[%0d]", d), rres[d], mres[d]);
                chk($sformatf("resp_zero[%0d]", d), {31'b0, rz[d]}, {31'b0, mz[d]});
            end
            chk($sformatf("alu_ctrl[%0d]", d), {29'b0, ac[d]}, {29'b0, (inflight[d] && age[d] == 1) ? mctrl[d] : `ALU_OP_ADD});
            chk($sformatf("alu_a[%0d]", d), aa[d], (inflight[d] && age[d] == 1) ? ma[d] : 32'd0);
        end
        refill();
    endtask

    task automatic drain();
        prob = 0;
        rr = 1'b1;
        fl = 1'b0;
        for (int d = 0; d < 2; d++) v[d] = 2'b00;
        repeat (3) cycle();
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            v[d] = 2'b00;
            inflight[d] = 0;
            age[d] = 0;
            lg[d] = 1'b1;
            for (int p = 0; p < 2; p++) begin
                ra[d][p] = '0;
                rb[d][p] = '0;
                rc[d][p] = '0;
                rm[d][p] = 1'b0;
                ogr[d][p] = 0;
            end
        end
        // reset state
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("rst_resp_valid", {31'b0, rv[d]}, 0);
            chk("rst_result", rres[d], 0);
            chk("rst_ready", {30'b0, rdy[d]}, 0);
            chk("rst_alu_ctrl", {29'b0, ac[d]}, {29'b0, `ALU_OP_ADD});
        end
        repeat (2) cycle();
        rst_n = 1'b1;
        // single SUB on port 0: accept, execute, respond
        rr = 1'b1;
        req(0, 32'd5, 32'd3, `ALU_OP_SUB);
        cycle();
        for (int d = 0; d < 2; d++) begin
            chk("t1_ready", {30'b0, prer[d]}, 1);
            chk("t1_ctrl", {29'b0, ac[d]}, {29'b0, `ALU_OP_SUB});
        end
        cycle();
        for (int d = 0; d < 2; d++) begin
            chk("t1_valid", {31'b0, rv[d]}, 1);
            chk("t1_id", {31'b0, rid[d]}, 0);
            chk("t1_result", rres[d], 2);
            chk("t1_zero", {31'b0, rz[d]}, 0);
        end
        // both ports always valid, response always taken
        prob = 100;
        refill();
        for (int d = 0; d < 2; d++) begin
            ogr[d][0] = 0;
            ogr[d][1] = 0;
        end
        repeat (16) cycle();
        chk("rr_port0", ogr[0][0], 4);
        chk("rr_port1", ogr[0][1], 4);
        chk("fixed_port0", ogr[1][0], 8);
        chk("fixed_port1", ogr[1][1], 0);
        // response held back for 4 cycles while port 1 waits
        drain();
        req(1, 32'd100, 32'd1, `ALU_OP_ADD);
        cycle();
        cycle();
        req(1, 32'd9, 32'd4, `ALU_OP_SUB);
        rr = 1'b0;
        for (int d = 0; d < 2; d++) held[d] = rres[d];
        repeat (4) begin
            cycle();
            for (int d = 0; d < 2; d++) begin
                chk("bp_hold", rres[d], held[d]);
                chk("bp_ready", {30'b0, prer[d]}, 0);
            end
        end
        rr = 1'b1;
        cycle();
        for (int d = 0; d < 2; d++) chk("bp_accept", {30'b0, prer[d]}, 2);
        cycle();
        cycle();
        for (int d = 0; d < 2; d++) chk("bp_result", rres[d], 5);
        // flush during execute drops the op
        drain();
        req(0, 32'd7, 32'd7, `ALU_OP_SUB);
        cycle();
        fl = 1'b1;
        cycle();
        fl = 1'b0;
        cycle();
        for (int d = 0; d < 2; d++) chk("flush_no_resp", {31'b0, rv[d]}, 0);
        req(0, 32'd7, 32'd7, `ALU_OP_SUB);
        repeat (2) cycle();
        for (int d = 0; d < 2; d++) begin
            chk("flush_next_valid", {31'b0, rv[d]}, 1);
            chk("flush_next_zero", {31'b0, rz[d]}, 1);
        end
        // randomized traffic with back-pressure and occasional flush
        prob = 40;
        repeat (400) begin
            rr = $urandom_range(3) != 0;
            fl = $urandom_range(29) == 0;
            cycle();
        end
        // asynchronous reset while a response is pending
        drain();
        req(0, 32'd1, 32'd2, `ALU_OP_ADD);
        cycle();
        cycle();
        req(0, 32'd3, 32'd3, `ALU_OP_ADD);
        req(1, 32'd4, 32'd4, `ALU_OP_ADD);
        rr = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("arst_valid", {31'b0, rv[d]}, 0);
            chk("arst_result", rres[d], 0);
            chk("arst_ready", {30'b0, rdy[d]}, 0);
        end
        cycle();
        rst_n = 1'b1;
        rr = 1'b1;
        cycle();
        for (int d = 0; d < 2; d++) chk("arst_first_grant", {30'b0, prer[d]}, 1);
        repeat (3) cycle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single combinational ALU between two requesters: port 0 is the execute stage and port 1 is the branch/address unit.
- Each requester uses a valid/ready request channel. The arbiter accepts one operation, drives the ALU operands and control for one cycle, registers the result, and returns it on a shared response channel tagged with the requester ID.
- Sits between the decode/issue logic (which supplies ALUControl and ALUModifier codes) and the ALU.

Parameters:
- XLEN, 32, operand/result width.
- PRIO_FIXED, 0: 0 = round-robin between ports; 1 = port 0 always wins when both request.

Ports:
- clk_i  input  1  clock
- rst_ni  input  1  asynchronous active-low reset
- flush_i  input  1  synchronous abort of the in-flight operation
- req_valid_i  input  2  per-port request valid
- req_ready_o  output  2  per-port request accept
- req0_a_i, req0_b_i  input  XLEN each  port 0 operands
- req0_ctrl_i  input  3  port 0 ALU control code (`ALU_OP_*)
- req0_mod_i  input  1  port 0 ALU modifier
- req1_a_i, req1_b_i, req1_ctrl_i, req1_mod_i  input  XLEN/XLEN/3/1  port 1 equivalents
- alu_a_o, alu_b_o  output  XLEN  operands to the ALU
- alu_ctrl_o  output  3  to ALU control input
- alu_mod_o  output  1  to ALU modifier input
- alu_result_i  input  XLEN  ALU result (combinational, same cycle)
- alu_zero_i  input  1  ALU zero flag
- resp_valid_o  output  1  response valid
- resp_ready_i  input  1  response accept
- resp_id_o  output  1  ID of the port that owns the response
- resp_result_o  output  XLEN  registered result
- resp_zero_o  output  1  registered zero flag

Behaviour:
- Reset (async, rst_ni=0):
  - FSM goes to IDLE; last_grant=1, so port 0 wins first.
  - Operand, result and response registers clear to 0; resp_valid_o=0; req_ready_o=0.
  - ALU outputs are 0 with alu_ctrl_o=`ALU_OP_ADD and alu_mod_o=0.
  - An operation in flight at reset is discarded; no response is produced.
- Arbitration (combinational, only when accept_en=1):
  - accept_en = (state==IDLE) | (state==RESP & resp_ready_i).
  - Single valid port: that port wins.
  - Both valid: with PRIO_FIXED=0 the port != last_grant wins; with PRIO_FIXED=1 port 0 wins.
  - req_ready_o is one-hot for the winner and 0 otherwise. The handshake completes when valid & ready.
- FSM:
  - IDLE: on handshake, latch operands/ctrl/mod/ID into op registers, last_grant<=winner, go to EXEC; otherwise stay.
  - EXEC (exactly 1 cycle): ALU outputs driven from op registers. Capture alu_result_i/alu_zero_i into response registers, then go to RESP.
  - RESP: resp_valid_o=1 with stable resp_id_o/result/zero until resp_ready_i.
    - On resp_ready_i with a new handshake in the same cycle: go to EXEC.
    - On resp_ready_i with no new request: go to IDLE.
    - Without resp_ready_i: stay, req_ready_o=0.
- ALU outputs outside EXEC: operands 0, alu_ctrl_o=`ALU_OP_ADD, alu_mod_o=0.
- Latency: request accept to resp_valid_o is 2 cycles. Peak throughput is one operation per 2 cycles with resp_ready_i held high.
- flush_i (priority over all non-reset events):
  - From EXEC or RESP: go to IDLE; resp_valid_o drops the next cycle; the result is dropped.
  - req_ready_o=0 while flush_i=1, so no accept happens in the flush cycle.
  - last_grant is not changed.
- Requester obligation: operands must stay stable while valid & !ready. The arbiter does not check this.

Optional Feature:
- Macro ALU_ARB_PERF_CNT_EN.
- Defined:
  - Adds outputs grant_cnt0_o and grant_cnt1_o (32 bits each), counting accepted handshakes per port.
  - Counters wrap at 2^32, reset to 0, and are not affected by flush_i.
  - Adds output stall_cnt_o (32 bits), counting cycles where any req_valid_i=1 but no handshake occurred.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset release, port 0 valid with a=5, b=3, ctrl=`ALU_OP_SUB -> ready0=1 in cycle 0; alu_ctrl_o=SUB in cycle 1; resp_valid_o=1, id=0, result=2, zero=0 in cycle 2.
- Both ports valid continuously, resp_ready_i=1, PRIO_FIXED=0 -> grants alternate 0,1,0,1; one response every 2 cycles; IDs match the grant order.
- Same stimulus with PRIO_FIXED=1 -> port 0 granted every time; req_ready_o[1] never asserts.
- resp_ready_i=0 for 4 cycles in RESP, port 1 valid -> response fields stable; req_ready_o=0; port 1 accepted in the cycle resp_ready_i rises; its response follows 2 cycles later.
- flush_i pulsed in EXEC with a=b=7, ctrl=SUB -> no resp_valid_o; FSM in IDLE; the next request is answered normally with zero=1 for a=b.
- rst_ni dropped in RESP -> all outputs 0 immediately (async); after release, the first grant goes to port 0 when both ports request.
